param_exec_unit: RTL and testbench
==================================

Name: param_exec_unit

Overview:
- Next-generation execution unit: parametrised register file plus multi-cycle ALU with a start/busy/done handshake and a 4-bit flag register.
- Operands are read directly from any two registers; results go to any destination register. There is no staging through fixed operand registers.
- Sits under the instruction sequencer, which drives start/op/src/dst and the direct load port, and reads registers through the registered read port.

Parameters:
- WIDTH, 8, data width of registers and ALU (>= 2)
- NREGS, 8, number of general registers (>= 2)
- AW, $clog2(NREGS), derived localparam, register address width

Ports:
- clock  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  direct register write (load immediate / load from RAM)
- wr_addr  in  AW  direct write address
- wr_data  in  WIDTH  direct write data
- rd_addr  in  AW  read port address
- rd_data  out  WIDTH  registered read data (1-cycle latency)
- start  in  1  request ALU op; sampled only in IDLE
- op  in  4  operation code
- src_a  in  AW  operand A register
- src_b  in  AW  operand B register
- dst  in  AW  destination register
- busy  out  1  high while state != IDLE
- done  out  1  one-cycle pulse after writeback
- flags  out  4  [0] Z zero, [1] C carry/borrow, [2] S shifted-out bit, [3] V signed overflow

Behaviour:
- Reset (async, rst_n=0):
  - all registers, flags, rd_data and done clear to 0; state = IDLE.
  - Reset mid-operation aborts the op with no register write and no flag update.
- FSM IDLE -> EXEC -> WB -> IDLE:
  - IDLE: on start=1 at edge T, capture regs[src_a], regs[src_b], op and dst; go to EXEC.
  - EXEC: compute result and flags into internal registers at edge T+1; go to WB.
  - WB: at edge T+2 write regs[dst] (unless no-write op), update flags, done<=1, go to IDLE.
  - done is high between T+2 and T+3. busy is high between T and T+2.
  - Earliest next start is sampled at edge T+3 (3 cycles per op).
- start while busy: ignored, not queued. op, src and dst are only looked at at the capture edge.
- Ops:
  - 0 ADD: A+B.
  - 1 SUB: A-B.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 SHL: A<<1, S=A[MSB].
  - 6 SHR: A>>1 logical, S=A[0].
  - 7 CMP: A-B, flags only, no write.
  - 8 INC: A+1.
  - 9 DEC: A-1.
  - 10 ADC: A+B+C.
  - 11 SBB: A-B-C.
  - 12 MOV: A.
  - 13-15: NOP. No write, flags unchanged, done still pulses.
- Arithmetic is computed at WIDTH+1 bits:
  - C = carry-out for add-type ops.
  - C = borrow (1 when A < B+cin unsigned) for sub-type ops and CMP.
  - V = two's-complement overflow.
  - Z = (result[WIDTH-1:0] == 0), updated by every op except NOP.
  - Logic ops and MOV clear C and V. S is changed only by shifts. Shifts clear C and V.
  - ADC/SBB use the flags.C value present at the capture edge.
  - Wrap-around is modular: INC of all-ones gives 0 with C=1, Z=1. DEC of 0 gives all-ones with C=1.
- Direct write port:
  - wr_en writes wr_data to regs[wr_addr] at any edge, including while busy.
  - If it coincides with the WB write to the same address, the ALU writeback wins.
  - If the same edge as capture targets src_a/src_b, the captured operand is the old value.
- Read port:
  - rd_data <= regs[rd_addr] every edge.
  - A read of an address written at the same edge returns the old value.
- Address range: addresses >= NREGS (non-power-of-2 NREGS) are ignored on write and read 0.

Decomposition:
- Package param_exec_pkg holds:
  - op encodings (OP_ADD..OP_MOV)
  - flag bit indices FLG_Z, FLG_C, FLG_S, FLG_V
  - FSM state enum
- One sub-module: param_alu, purely combinational, parametrised by WIDTH. Inputs a, b, op, cin; outputs result, c, s, v, z, wr_valid.

Test Plan:
- Reset with WIDTH=8: regs, flags, rd_data all 0; busy=0, done=0.
- Load r1=0x7F, r2=0x01 via wr_en; ADD r1,r2->r3 -> done 3 cycles after start; r3=0x80; flags V=1, C=0, Z=0.
- SUB r2,r1->r4 (0x01-0x7F) -> r4=0x82, C=1. Then SBB r4,r2->r5 -> r5=0x80.
- Load r6=0xFF; INC r6->r6 -> r6=0x00, Z=1, C=1. SHR on 0x01 -> 0x00, S=1, Z=1.
- Issue start again while busy -> ignored, exactly one done. wr_en to dst at WB edge -> ALU value retained.
- Assert rst_n=0 during EXEC of ADD -> dst unchanged, no done; WIDTH=16, NREGS=5 build passes the same ADD/overflow check with 0x7FFF+1.

Source files
------------

// File: rtl/param_exec_pkg.sv
// Shared encodings for the execution unit: op codes, flag bit positions, FSM states.
package param_exec_pkg;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_SHL = 4'd5;
   localparam logic [3:0] OP_SHR = 4'd6;
   localparam logic [3:0] OP_CMP = 4'd7;
   localparam logic [3:0] OP_INC = 4'd8;
   localparam logic [3:0] OP_DEC = 4'd9;
   localparam logic [3:0] OP_ADC = 4'd10;
   localparam logic [3:0] OP_SBB = 4'd11;
   localparam logic [3:0] OP_MOV = 4'd12;

   localparam int FLG_Z = 0;
   localparam int FLG_C = 1;
   localparam int FLG_S = 2;
   localparam int FLG_V = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_WB   = 2'd2
   } state_e;

   // Codes above MOV do nothing but still complete the handshake.
   function automatic logic op_is_nop(input logic [3:0] op);
      return op > OP_MOV;
   endfunction

   // Only shifts are allowed to touch the S flag.
   function automatic logic op_is_shift(input logic [3:0] op);
      return (op == OP_SHL) || (op == OP_SHR);
   endfunction

endpackage

// File: rtl/param_alu.sv
// Combinational ALU: one WIDTH+1 adder and one WIDTH+1 subtractor feed all
// arithmetic ops; carry/borrow come from the extra top bit.
module param_alu
   import param_exec_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   input  logic             cin,
   output logic [WIDTH-1:0] result,
   output logic             c,
   output logic             s,
   output logic             v,
   output logic             z,
   output logic             wr_valid
);

   localparam int MSB = WIDTH - 1;

   logic [WIDTH-1:0] b_sel;
   logic             ci;
   logic [WIDTH:0]   ci_ext;
   logic [WIDTH:0]   add_res;
   logic [WIDTH:0]   sub_res;

   // INC/DEC reuse the adder/subtractor with a constant 1; only ADC/SBB take the carry in.
   assign b_sel   = (op == OP_INC || op == OP_DEC) ? WIDTH'(1) : b;
   assign ci      = (op == OP_ADC || op == OP_SBB) ? cin : 1'b0;
   assign ci_ext  = {{WIDTH{1'b0}}, ci};
   assign add_res = {1'b0, a} + {1'b0, b_sel} + ci_ext;
   assign sub_res = {1'b0, a} - {1'b0, b_sel} - ci_ext;

   // Op select; the sign-based V terms are exact even with a carry/borrow in.
   always_comb begin
      result   = '0;
      c        = 1'b0;
      s        = 1'b0;
      v        = 1'b0;
      wr_valid = 1'b1;
      case (op)
         OP_ADD, OP_ADC, OP_INC: begin
            result = add_res[WIDTH-1:0];
            c      = add_res[WIDTH];
            v      = (a[MSB] == b_sel[MSB]) && (add_res[MSB] != a[MSB]);
         end
         OP_SUB, OP_SBB, OP_DEC, OP_CMP: begin
            result   = sub_res[WIDTH-1:0];
            c        = sub_res[WIDTH];
            v        = (a[MSB] != b_sel[MSB]) && (sub_res[MSB] != a[MSB]);
            wr_valid = (op != OP_CMP);
         end
         OP_AND: result = a & b;
         OP_OR:  result = a | b;
         OP_XOR: result = a ^ b;
         OP_SHL: begin
            result = {a[WIDTH-2:0], 1'b0};
            s      = a[MSB];
         end
         OP_SHR: begin
            result = {1'b0, a[WIDTH-1:1]};
            s      = a[0];
         end
         OP_MOV: result = a;
         default: wr_valid = 1'b0;
      endcase
   end

   assign z = (result == '0);

endmodule

// File: rtl/param_exec_unit.sv
// Register file plus 3-cycle ALU (capture, execute, writeback) with a
// start/busy/done handshake and a 4-bit flag register.
module param_exec_unit
   import param_exec_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int NREGS = 8,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [AW-1:0]    src_a,
   input  logic [AW-1:0]    src_b,
   input  logic [AW-1:0]    dst,
   output logic             busy,
   output logic             done,
   output logic [3:0]       flags
);

   logic [WIDTH-1:0] regs [NREGS];
   state_e           state;

   // Captured request
   logic [WIDTH-1:0] opa_q, opb_q;
   logic [3:0]       op_q;
   logic [AW-1:0]    dst_q;
   logic             cin_q;

   // Executed result waiting for writeback
   logic [WIDTH-1:0] res_q;
   logic             wr_q;
   logic [3:0]       nflags_q;

   logic [WIDTH-1:0] alu_res;
   logic             alu_c, alu_s, alu_v, alu_z, alu_wr;
   logic             wb_we;

   // Addresses past NREGS match no register, so they read as 0.
   function automatic logic [WIDTH-1:0] reg_at(input logic [AW-1:0] addr);
      logic [WIDTH-1:0] val;
      val = '0;
      for (int i = 0; i < NREGS; i++)
         if (addr == AW'(i)) val = regs[i];
      return val;
   endfunction

   param_alu #(.WIDTH(WIDTH)) u_alu (
      .a        (opa_q),
      .b        (opb_q),
      .op       (op_q),
      .cin      (cin_q),
      .result   (alu_res),
      .c        (alu_c),
      .s        (alu_s),
      .v        (alu_v),
      .z        (alu_z),
      .wr_valid (alu_wr)
   );

   assign busy  = (state != ST_IDLE);
   assign wb_we = (state == ST_WB) && wr_q;

   // Sequencer: capture operands in IDLE, register ALU outputs in EXEC, pulse done in WB.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         done     <= 1'b0;
         opa_q    <= '0;
         opb_q    <= '0;
         op_q     <= '0;
         dst_q    <= '0;
         cin_q    <= 1'b0;
         res_q    <= '0;
         wr_q     <= 1'b0;
         nflags_q <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  opa_q <= reg_at(src_a);
                  opb_q <= reg_at(src_b);
                  op_q  <= op;
                  dst_q <= dst;
                  cin_q <= flags[FLG_C];
                  state <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               res_q           <= alu_res;
               wr_q            <= alu_wr;
               nflags_q[FLG_Z] <= alu_z;
               nflags_q[FLG_C] <= alu_c;
               nflags_q[FLG_V] <= alu_v;
               nflags_q[FLG_S] <= op_is_shift(op_q) ? alu_s : flags[FLG_S];
               state           <= ST_WB;
            end
            ST_WB: begin
               done  <= 1'b1;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Flags commit at writeback; NOP codes leave them untouched.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n)
         flags <= '0;
      else if (state == ST_WB && !op_is_nop(op_q))
         flags <= nflags_q;
   end

   // Register file: ALU writeback has priority over the direct load port.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            if (wb_we && dst_q == AW'(i))
               regs[i] <= res_q;
            else if (wr_en && wr_addr == AW'(i))
               regs[i] <= wr_data;
         end
      end
   end

   // Registered read port; sees pre-edge contents on a same-edge write.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n)
         rd_data <= '0;
      else
         rd_data <= reg_at(rd_addr);
   end

endmodule

// File: tb/tb_param_exec_unit.sv
// Bench for param_exec_unit: directed plan items plus randomized ops checked
// against an integer-arithmetic reference model; an 8x8 and a 16-bit/5-reg build.
module tb_param_exec_unit;
   import param_exec_pkg::*;

   logic clock = 1'b0;
   logic rst_n = 1'b0;
   always #5 clock = ~clock;

   // 8-bit, 8-register build
   logic       wr_en = 0, start = 0, busy, done;
   logic [2:0] wr_addr = 0, rd_addr = 0, src_a = 0, src_b = 0, dst = 0;
   logic [7:0] wr_data = 0, rd_data;
   logic [3:0] op = 0, flags;

   // 16-bit, 5-register build
   logic        h_wr_en = 0, h_start = 0, h_busy, h_done;
   logic [2:0]  h_wr_addr = 0, h_rd_addr = 0, h_src_a = 0, h_src_b = 0, h_dst = 0;
   logic [15:0] h_wr_data = 0, h_rd_data;
   logic [3:0]  h_op = 0, h_flags;

   param_exec_unit #(.WIDTH(8), .NREGS(8)) dut8 (
      .clock(clock), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .rd_data(rd_data), .start(start), .op(op), .src_a(src_a),
      .src_b(src_b), .dst(dst), .busy(busy), .done(done), .flags(flags));

   param_exec_unit #(.WIDTH(16), .NREGS(5)) dut16 (
      .clock(clock), .rst_n(rst_n), .wr_en(h_wr_en), .wr_addr(h_wr_addr), .wr_data(h_wr_data),
      .rd_addr(h_rd_addr), .rd_data(h_rd_data), .start(h_start), .op(h_op), .src_a(h_src_a),
      .src_b(h_src_b), .dst(h_dst), .busy(h_busy), .done(h_done), .flags(h_flags));

   int n_cmp = 0, n_err = 0;
   longint     m8 [8];
   logic [3:0] f8 = 0;
   longint     m16 [5];
   logic [3:0] f16 = 0;

   task automatic check(input string tag, input longint got, input longint exp);
      n_cmp++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic on unsigned and signed interpretations.
   task automatic model_exec(input int w, input int o, input longint a, input longint b,
                             input logic [3:0] fi, output longint res,
                             output logic [3:0] fo, output bit wr);
      longint mask, smax, smin, sa, sx, x, ci, u, sv;
      mask = (longint'(1) << w) - 1;
      smax = (longint'(1) << (w - 1)) - 1;
      smin = -smax - 1;
      fo = fi; wr = 1; res = 0;
      if (o >= 13) begin wr = 0; return; end
      x  = (o == 8 || o == 9) ? 1 : b;
      ci = (o == 10 || o == 11) ? longint'(fi[1]) : 0;
      sa = (a > smax) ? a - mask - 1 : a;
      sx = (x > smax) ? x - mask - 1 : x;
      fo[1] = 0; fo[3] = 0;
      case (o)
         0, 8, 10: begin
            u = a + x + ci; sv = sa + sx + ci; res = u & mask;
            fo[1] = (u > mask); fo[3] = (sv > smax) || (sv < smin);
         end
         1, 7, 9, 11: begin
            u = a - x - ci; sv = sa - sx - ci; res = u & mask;
            fo[1] = (u < 0); fo[3] = (sv > smax) || (sv < smin);
            if (o == 7) wr = 0;
         end
         2: res = a & b;
         3: res = a | b;
         4: res = a ^ b;
         5: begin res = (a * 2) & mask; fo[2] = (a > smax); end
         6: begin res = a / 2; fo[2] = ((a % 2) == 1); end
         default: res = a;
      endcase
      fo[0] = (res == 0);
   endtask

   function automatic int pick8();
      case ($urandom_range(0, 5))
         0: return 0;
         1: return 1;
         2: return 'h7F;
         3: return 'h80;
         4: return 'hFF;
         default: return int'($urandom_range(0, 255));
      endcase
   endfunction

   task automatic wr8(input int a, input int d);
      wr_en = 1; wr_addr = 3'(a); wr_data = 8'(d);
      @(posedge clock); m8[a] = d;
      @(negedge clock); wr_en = 0;
   endtask

   task automatic rdc8(input int a, input string tag, input longint exp);
      rd_addr = 3'(a);
      @(posedge clock); @(negedge clock);
      check(tag, rd_data, exp);
   endtask

   // One op; wcyc selects which edge (0=capture .. 2=writeback) carries a direct write.
   task automatic op8(input int o, input int a_i, input int b_i, input int d,
                      input int wcyc, input int wa, input int wd, input bit spam);
      longint res; logic [3:0] nf; bit wr;
      model_exec(8, o, m8[a_i], m8[b_i], f8, res, nf, wr);
      start = 1; op = 4'(o); src_a = 3'(a_i); src_b = 3'(b_i); dst = 3'(d);
      for (int k = 0; k < 4; k++) begin
         wr_en = (wcyc == k); wr_addr = 3'(wa); wr_data = 8'(wd);
         @(posedge clock);
         if (wcyc == k) m8[wa] = wd;
         if (k == 2) begin
            if (wr) m8[d] = res;
            f8 = nf;
         end
         @(negedge clock);
         wr_en = 0;
         start = spam && (k < 2);
         op = 4'($urandom); src_a = 3'($urandom); src_b = 3'($urandom); dst = 3'($urandom);
         check("op_busy", busy, (k < 2));
         check("op_done", done, (k == 2));
         if (k == 2) check("op_flags", flags, f8);
      end
   endtask

   task automatic wr16(input int a, input int d);
      h_wr_en = 1; h_wr_addr = 3'(a); h_wr_data = 16'(d);
      @(posedge clock); if (a < 5) m16[a] = d;
      @(negedge clock); h_wr_en = 0;
   endtask

   task automatic rd16(input int a, input string tag);
      h_rd_addr = 3'(a);
      @(posedge clock); @(negedge clock);
      check(tag, h_rd_data, (a < 5) ? m16[a] : 0);
   endtask

   task automatic op16(input int o, input int a_i, input int b_i, input int d);
      longint res, av, bv; logic [3:0] nf; bit wr;
      av = (a_i < 5) ? m16[a_i] : 0;
      bv = (b_i < 5) ? m16[b_i] : 0;
      model_exec(16, o, av, bv, f16, res, nf, wr);
      h_start = 1; h_op = 4'(o); h_src_a = 3'(a_i); h_src_b = 3'(b_i); h_dst = 3'(d);
      for (int k = 0; k < 4; k++) begin
         @(posedge clock);
         if (k == 2) begin
            if (wr && d < 5) m16[d] = res;
            f16 = nf;
         end
         @(negedge clock);
         h_start = 0;
         check("op16_done", h_done, (k == 2));
         if (k == 2) check("op16_flags", h_flags, f16);
      end
   endtask

   initial begin
      foreach (m8[i]) m8[i] = 0;
      foreach (m16[i]) m16[i] = 0;

      // Reset state
      #12;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_flags", flags, 0);
      check("rst_rd", rd_data, 0);
      check("rst_busy16", h_busy, 0);
      @(negedge clock); rst_n = 1;
      for (int i = 0; i < 8; i++) rdc8(i, "rst_reg", 0);

      // Directed plan items
      wr8(1, 'h7F); wr8(2, 'h01);
      op8(OP_ADD, 1, 2, 3, -1, 0, 0, 0);
      check("add_flags", flags, 4'b1000);
      rdc8(3, "add_r3", 'h80);
      op8(OP_SUB, 2, 1, 4, -1, 0, 0, 0);
      check("sub_flags", flags, 4'b0010);
      rdc8(4, "sub_r4", 'h82);
      op8(OP_SBB, 4, 2, 5, -1, 0, 0, 0);
      rdc8(5, "sbb_r5", 'h80);
      wr8(6, 'hFF);
      op8(OP_INC, 6, 6, 6, -1, 0, 0, 0);
      check("inc_flags", flags, 4'b0011);
      rdc8(6, "inc_r6", 'h00);
      wr8(7, 'h01);
      op8(OP_SHR, 7, 7, 7, -1, 0, 0, 0);
      check("shr_flags", flags, 4'b0101);
      rdc8(7, "shr_r7", 'h00);
      op8(OP_ADD, 1, 2, 0, -1, 0, 0, 1);          // start held while busy
      rdc8(0, "spam_r0", 'h80);
      op8(OP_MOV, 1, 1, 3, 2, 3, 'h55, 0);        // load collides with writeback
      rdc8(3, "wb_wins", 'h7F);
      op8(OP_MOV, 2, 2, 4, 0, 2, 'h33, 0);        // load to source at capture edge
      rdc8(4, "cap_old", 'h01);
      rdc8(2, "cap_new", 'h33);
      op8(OP_CMP, 1, 2, 1, -1, 0, 0, 0);          // flags only
      rdc8(1, "cmp_nowr", 'h7F);

      // Same-edge read and write returns the old value
      rd_addr = 5; wr_en = 1; wr_addr = 5; wr_data = 'h11;
      @(posedge clock); @(negedge clock);
      wr_en = 0;
      check("rw_old", rd_data, m8[5]);
      m8[5] = 'h11;
      @(posedge clock); @(negedge clock);
      check("rw_new", rd_data, 'h11);

      // Randomized ops against the model
      for (int it = 0; it < 200; it++) begin
         int o, a, b, d;
         if ($urandom_range(0, 2) == 0) wr8(int'($urandom_range(0, 7)), pick8());
         o = int'($urandom_range(0, 15));
         a = int'($urandom_range(0, 7));
         b = int'($urandom_range(0, 7));
         d = int'($urandom_range(0, 7));
         op8(o, a, b, d, int'($urandom_range(0, 5)), int'($urandom_range(0, 7)), pick8(),
             1'($urandom_range(0, 1)));
         rdc8(d, "rand_dst", m8[d]);
      end
      for (int i = 0; i < 8; i++) rdc8(i, "rand_final", m8[i]);

      // 16-bit / 5-register build
      wr16(0, 'h7FFF); wr16(1, 1); wr16(6, 'hBEEF);
      rd16(6, "w16_oob");
      op16(OP_ADD, 0, 1, 2);
      check("w16_add_flags", h_flags, 4'b1000);
      rd16(2, "w16_add");
      check("w16_add_const", h_rd_data, 'h8000);
      op16(OP_ADD, 0, 6, 3);                      // out-of-range source reads 0
      rd16(3, "w16_oob_src");
      op16(OP_DEC, 4, 4, 4);
      rd16(4, "w16_dec");
      check("w16_dec_const", h_rd_data, 'hFFFF);

      // Reset during EXEC aborts the op
      start = 1; op = OP_ADD; src_a = 1; src_b = 2; dst = 3;
      @(posedge clock); @(negedge clock);
      start = 0;
      check("abort_busy", busy, 1);
      rst_n = 0;
      #1;
      check("abort_busy_rst", busy, 0);
      check("abort_flags", flags, 0);
      foreach (m8[i]) m8[i] = 0;
      foreach (m16[i]) m16[i] = 0;
      f8 = 0; f16 = 0;
      repeat (2) @(negedge clock);
      rst_n = 1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         check("abort_nodone", done, 0);
      end
      rdc8(3, "abort_dst", 0);
      check("abort_flags2", flags, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
